// File: rtl/loader_pkg.sv
// Shared constants for the boot-time program loader.
// State encoding, RAM handshake constants, default sizes.
package loader_pkg;

  localparam logic [2:0] HDR_HI  = 3'd0;
  localparam logic [2:0] HDR_LO  = 3'd1;
  localparam logic [2:0] COLLECT = 3'd2;
  localparam logic [2:0] WRITE   = 3'd3;
  localparam logic [2:0] CHECK   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERROR   = 3'd6;

  localparam logic [1:0] DL_WORD  = 2'b10;
  localparam logic       RW_WRITE = 1'b0;

  localparam int DEF_MAX_WORDS   = 128;
  localparam int DEF_MOC_TIMEOUT = 15;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian word assembler: shifts accepted bytes into a 32-bit word.
// Ports: clk, reset, byte_valid, byte_in -> word, word_ready (4th byte).
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (byte_valid) begin
      word_d = {word_q[23:0], byte_in};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word       = word_q;
  assign word_ready = byte_valid && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot loader: byte stream -> 32-bit RAM writes via MOV/MOC, then
// releases cpu_reset. Ports: main_clk, reset, in_* stream, mem_* RAM,
// cpu_reset, load_done, load_error. LOADER_CHECKSUM_EN adds XOR trailer.
module program_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS   = DEF_MAX_WORDS,
  parameter int MOC_TIMEOUT = DEF_MOC_TIMEOUT
) (
  input  logic        main_clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_mov,
  output logic        mem_rw,
  output logic        mem_sig,
  output logic [1:0]  mem_dl,
  output logic [8:0]  mem_address,
  output logic [31:0] mem_data,
  input  logic        mem_moc,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam int TW = $clog2(MOC_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MOC_TIMEOUT - 1);

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] LAST_ST = CHECK;
`else
  localparam logic [2:0] LAST_ST = DONE;
`endif

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [8:0]    addr_q, addr_d;
  logic [TW-1:0] tmo_q, tmo_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic        accept;
  logic        pay_acc;
  logic        word_ready;
  logic [31:0] word;
  logic [15:0] len_in;

  assign in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                    (state_q == COLLECT) || (state_q == CHECK);
  assign accept   = in_valid && in_ready;
  assign pay_acc  = accept && (state_q == COLLECT);
  assign len_in   = {len_hi_q, in_data};

  word_assembler u_asm (
    .clk       (main_clk),
    .reset     (reset),
    .byte_valid(pay_acc),
    .byte_in   (in_data),
    .word      (word),
    .word_ready(word_ready)
  );

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    tmo_d    = tmo_q;
    case (state_q)
      HDR_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          len_d = len_in;
          if (len_in > 16'(MAX_WORDS)) state_d = ERROR;
          else if (len_in == 16'd0)    state_d = LAST_ST;
          else                         state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (word_ready) begin
          state_d = WRITE;
          tmo_d   = '0;
        end
      end
      WRITE: begin
        // moc accepted in any of the MOC_TIMEOUT write cycles
        if (mem_moc) begin
          addr_d = addr_q + 9'd4;
          wcnt_d = wcnt_q + 16'd1;
          tmo_d  = '0;
          if (wcnt_q + 16'd1 == len_q) state_d = LAST_ST;
          else                         state_d = COLLECT;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_d = (in_data == csum_q) ? DONE : ERROR;
      end
`endif
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (pay_acc) csum_d = csum_q ^ in_data;
  end
`endif

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q  <= HDR_HI;
      len_hi_q <= '0;
      len_q    <= '0;
      wcnt_q   <= '0;
      addr_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge main_clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  assign mem_mov     = (state_q == WRITE);
  assign mem_rw      = RW_WRITE;
  assign mem_sig     = 1'b0;
  assign mem_dl      = DL_WORD;
  assign mem_address = addr_q;
  assign mem_data    = word;
  assign load_done   = (state_q == DONE);
  assign load_error  = (state_q == ERROR);
  assign cpu_reset   = (state_q != DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
// Small RAM model answers MOV with MOC after a programmable delay.
module tb_program_loader;

  logic        main_clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_mov;
  logic        mem_rw;
  logic        mem_sig;
  logic [1:0]  mem_dl;
  logic [8:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_moc;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  program_loader dut (
    .main_clk   (main_clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_mov    (mem_mov),
    .mem_rw     (mem_rw),
    .mem_sig    (mem_sig),
    .mem_dl     (mem_dl),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_moc    (mem_moc),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  int n_chk;
  int n_pass;
  int mov_cycles;
  int viol;
  int moc_delay;
  int wait_cnt;
  bit ram_en;
  logic [8:0]  wa[$];
  logic [31:0] wd[$];
  logic [31:0] img[$];

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // RAM model: MOC once MOV has been high for moc_delay cycles
  initial begin
    mem_moc  = 1'b0;
    wait_cnt = 0;
    forever begin
      @(posedge main_clk);
      #1;
      if (mem_mov && ram_en) begin
        wait_cnt++;
        mem_moc = (wait_cnt >= moc_delay);
      end else begin
        wait_cnt = 0;
        mem_moc  = 1'b0;
      end
    end
  end

  // monitor: values at negedge equal those seen at the next posedge
  initial begin
    forever begin
      @(negedge main_clk);
      if (!reset) begin
        if (mem_mov) mov_cycles++;
        if (mem_mov && in_ready) viol++;
        if (mem_mov && mem_moc) begin
          wa.push_back(mem_address);
          wd.push_back(mem_data);
        end
      end
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge main_clk);
    #1;
    @(posedge main_clk);
    #1;
    reset      = 1'b0;
    mov_cycles = 0;
    viol       = 0;
    wa.delete();
    wd.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int k;
    acc      = 1'b0;
    k        = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && k < 100) begin
      @(negedge main_clk);
      acc = in_ready;
      @(posedge main_clk);
      #1;
      k++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic send_image(input logic [15:0] n);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (img[i]) begin
      for (int j = 3; j >= 0; j--) begin
        b = img[i][8*j +: 8];
        x = x ^ b;
        send_byte(b);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x);
`endif
    idle();
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(load_done || load_error) && k < 300) begin
      @(posedge main_clk);
      #1;
      k++;
    end
    chk("end_reached", {31'd0, load_done | load_error}, 32'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wcnt"}, wa.size(), img.size());
    foreach (img[i]) begin
      if (i < wa.size()) begin
        chk({tag, "_addr"}, {23'd0, wa[i]}, 32'(4 * i));
        chk({tag, "_data"}, wd[i], img[i]);
      end else begin
        chk({tag, "_missing"}, 32'd0, 32'd1);
      end
    end
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    moc_delay = 2;
    ram_en    = 1'b1;
    do_reset();

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_mov", {31'd0, mem_mov}, 32'd0);
    chk("rst_addr", {23'd0, mem_address}, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_error", {31'd0, load_error}, 32'd0);
    chk("rst_consts", {27'd0, mem_rw, mem_sig, mem_dl, 1'b0}, 32'h4);

    // two words, MOC after 2 cycles
    img = '{32'hE3A01005, 32'h00000000};
    send_image(16'd2);
    wait_end();
    check_writes("two");
    chk("two_done", {31'd0, load_done}, 32'd1);
    chk("two_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("two_error", {31'd0, load_error}, 32'd0);
    chk("two_in_ready", {31'd0, in_ready}, 32'd0);

    // oversize length
    do_reset();
    send_byte(8'h00);
    send_byte(8'h81);
    idle();
    chk("big_error", {31'd0, load_error}, 32'd1);
    chk("big_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (5) @(posedge main_clk);
    #1;
    chk("big_no_mov", mov_cycles, 32'd0);
    chk("big_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // MOC never arrives
    do_reset();
    ram_en = 1'b0;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    idle();
    chk("tmo_mov_up", {31'd0, mem_mov}, 32'd1);
    chk("tmo_data", mem_data, 32'hAABBCCDD);
    wait_end();
    chk("tmo_error", {31'd0, load_error}, 32'd1);
    chk("tmo_mov_cycles", mov_cycles, 32'd15);
    chk("tmo_mov_low", {31'd0, mem_mov}, 32'd0);
    chk("tmo_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("tmo_no_write", wa.size(), 32'd0);
    ram_en = 1'b1;

`ifdef LOADER_CHECKSUM_EN
    // good trailer
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h08);
    send_byte(8'h0F);
    idle();
    wait_end();
    img = '{32'h01020408};
    check_writes("cs_ok");
    chk("cs_ok_done", {31'd0, load_done}, 32'd1);

    // bad trailer
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h08);
    send_byte(8'h0E);
    idle();
    wait_end();
    check_writes("cs_bad");
    chk("cs_bad_error", {31'd0, load_error}, 32'd1);
    chk("cs_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
`endif

    // reset while MOV is held
    do_reset();
    ram_en = 1'b0;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    idle();
    @(posedge main_clk);
    #1;
    chk("rw_mov_before", {31'd0, mem_mov}, 32'd1);
    reset = 1'b1;
    @(posedge main_clk);
    #1;
    chk("rw_mov_after", {31'd0, mem_mov}, 32'd0);
    chk("rw_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rw_addr", {23'd0, mem_address}, 32'd0);
    do_reset();
    ram_en    = 1'b1;
    moc_delay = 1;
    img = '{32'hDEADBEEF};
    send_image(16'd1);
    wait_end();
    check_writes("reload");
    chk("reload_done", {31'd0, load_done}, 32'd1);

    // back-to-back bytes, no gaps from the source
    do_reset();
    moc_delay = 3;
    img = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C};
    send_image(16'd3);
    wait_end();
    check_writes("burst");
    chk("burst_ready_low", viol, 32'd0);
    chk("burst_done", {31'd0, load_done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
